// File: rtl/rename_map_table_if.sv
// Rename map table port bundle: rename request/response, free-list handshake,
// checkpoint control and performance counters.
interface rename_map_table_if #(
  parameter int ARCH_REGS  = 32,
  parameter int PHYS_W     = 8,
  parameter int CKPT_DEPTH = 8
);
  localparam int AW = $clog2(ARCH_REGS);
  localparam int CW = $clog2(CKPT_DEPTH);

  logic              rn_valid;
  logic              rn_ready;
  logic [AW-1:0]     rs1_addr;
  logic [AW-1:0]     rs2_addr;
  logic              use_rs1;
  logic              use_rs2;
  logic [AW-1:0]     rd_addr;
  logic              rd_we;

  logic [PHYS_W-1:0] free_phys;
  logic              free_valid;
  logic              free_pop;

  logic              ckpt_save;
  logic              restore_valid;
  logic [CW-1:0]     restore_id;
  logic              ckpt_release;
  logic              ckpt_full;

  logic              out_valid;
  logic [PHYS_W-1:0] ps1;
  logic [PHYS_W-1:0] ps2;
  logic [PHYS_W-1:0] pd;
  logic [PHYS_W-1:0] old_pd;
  logic [AW-1:0]     rd_arch;
  logic [CW-1:0]     ckpt_id;
  logic [31:0]       perf_rename_cnt;
  logic [31:0]       perf_stall_cnt;

  modport master (
    output rn_valid, rs1_addr, rs2_addr, use_rs1, use_rs2, rd_addr, rd_we,
           free_phys, free_valid, ckpt_save, restore_valid, restore_id, ckpt_release,
    input  rn_ready, free_pop, ckpt_full, out_valid, ps1, ps2, pd, old_pd,
           rd_arch, ckpt_id, perf_rename_cnt, perf_stall_cnt
  );

  modport slave (
    input  rn_valid, rs1_addr, rs2_addr, use_rs1, use_rs2, rd_addr, rd_we,
           free_phys, free_valid, ckpt_save, restore_valid, restore_id, ckpt_release,
    output rn_ready, free_pop, ckpt_full, out_valid, ps1, ps2, pd, old_pd,
           rd_arch, ckpt_id, perf_rename_cnt, perf_stall_cnt
  );
endinterface

// File: rtl/rename_map_table.sv
// Register alias table with a circular buffer of branch checkpoints.
// Optional performance counters are built when RMT_PERF_CNT_EN is defined.
module rename_map_table #(
  parameter int ARCH_REGS  = 32,
  parameter int PHYS_W     = 8,
  parameter int CKPT_DEPTH = 8
) (
  input logic               clk,
  input logic               reset,
  rename_map_table_if.slave bus
);
  localparam int AW = $clog2(ARCH_REGS);
  localparam int CW = $clog2(CKPT_DEPTH);

  localparam logic [PHYS_W-1:0] NONE       = '1;
  localparam logic [0:0]        ST_RUN     = 1'b0;
  localparam logic [0:0]        ST_RECOVER = 1'b1;

  typedef logic [PHYS_W-1:0] tag_t;

  tag_t          map_q  [ARCH_REGS];
  tag_t          map_d  [ARCH_REGS];
  tag_t          slot_q [CKPT_DEPTH][ARCH_REGS];
  tag_t          slot_d [CKPT_DEPTH][ARCH_REGS];
  logic [CW-1:0] head_q, head_d;
  logic [CW-1:0] tail_q, tail_d;
  logic [CW:0]   count_q, count_d;
  logic [0:0]    state_q, state_d;

  logic          out_valid_q, out_valid_d;
  tag_t          ps1_q, ps1_d;
  tag_t          ps2_q, ps2_d;
  tag_t          pd_q, pd_d;
  tag_t          old_pd_q, old_pd_d;
  logic [AW-1:0] rd_arch_q, rd_arch_d;
  logic [CW-1:0] ckpt_id_q, ckpt_id_d;

  logic          need_phys;
  logic          ckpt_full;
  logic          rn_ready;
  logic          accept;
  logic          save_ok;
  logic          release_ok;
  logic [CW-1:0] restore_off;
  logic          restore_hit;

  // A restore only counts when its slot lies in the live window head..tail-1.
  always_comb begin
    need_phys   = bus.rd_we && (bus.rd_addr != '0);
    ckpt_full   = (count_q == (CW+1)'(CKPT_DEPTH));
    restore_off = bus.restore_id - head_q;
    restore_hit = bus.restore_valid && ({1'b0, restore_off} < count_q);
    rn_ready    = (state_q == ST_RUN) && !bus.restore_valid &&
                  (!need_phys || bus.free_valid) && (!bus.ckpt_save || !ckpt_full);
    accept      = bus.rn_valid && rn_ready;
    save_ok     = accept && bus.ckpt_save;
    release_ok  = bus.ckpt_release && (count_q != '0) && !restore_hit;
  end

  always_comb begin
    map_d   = map_q;
    slot_d  = slot_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = ST_RUN;
    if (restore_hit) begin
      map_d   = slot_q[bus.restore_id];
      tail_d  = bus.restore_id + CW'(1);
      count_d = {1'b0, restore_off} + (CW+1)'(1);
      state_d = ST_RECOVER;
    end else begin
      if (accept && need_phys) begin
        map_d[bus.rd_addr] = bus.free_phys;
      end
      // The checkpoint captures the map including this instruction's own rename.
      if (save_ok) begin
        slot_d[tail_q] = map_d;
        tail_d         = tail_q + CW'(1);
      end
      if (release_ok) begin
        head_d = head_q + CW'(1);
      end
      count_d = count_q + (CW+1)'(save_ok) - (CW+1)'(release_ok);
    end
  end

  // Sources read the map as it stood before this cycle's destination update.
  always_comb begin
    out_valid_d = accept;
    ps1_d       = ps1_q;
    ps2_d       = ps2_q;
    pd_d        = pd_q;
    old_pd_d    = old_pd_q;
    rd_arch_d   = rd_arch_q;
    ckpt_id_d   = ckpt_id_q;
    if (accept) begin
      ps1_d     = bus.use_rs1 ? map_q[bus.rs1_addr] : NONE;
      ps2_d     = bus.use_rs2 ? map_q[bus.rs2_addr] : NONE;
      pd_d      = need_phys ? bus.free_phys : NONE;
      old_pd_d  = need_phys ? map_q[bus.rd_addr] : NONE;
      rd_arch_d = bus.rd_addr;
      ckpt_id_d = tail_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        map_q[i] <= PHYS_W'(i);
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      state_q     <= ST_RUN;
      out_valid_q <= 1'b0;
      ps1_q       <= '0;
      ps2_q       <= '0;
      pd_q        <= '0;
      old_pd_q    <= '0;
      rd_arch_q   <= '0;
      ckpt_id_q   <= '0;
    end else begin
      map_q       <= map_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      ps1_q       <= ps1_d;
      ps2_q       <= ps2_d;
      pd_q        <= pd_d;
      old_pd_q    <= old_pd_d;
      rd_arch_q   <= rd_arch_d;
      ckpt_id_q   <= ckpt_id_d;
    end
  end

  // Checkpoint storage is only meaningful once written, so it carries no reset.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

`ifdef RMT_PERF_CNT_EN
  logic [31:0] perf_rename_q, perf_rename_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_rename_d = perf_rename_q + 32'(accept);
    perf_stall_d  = perf_stall_q + 32'(bus.rn_valid && !rn_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_rename_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_rename_q <= perf_rename_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign bus.perf_rename_cnt = perf_rename_q;
  assign bus.perf_stall_cnt  = perf_stall_q;
`else
  assign bus.perf_rename_cnt = '0;
  assign bus.perf_stall_cnt  = '0;
`endif

  assign bus.rn_ready  = rn_ready;
  assign bus.free_pop  = accept && need_phys;
  assign bus.ckpt_full = ckpt_full;
  assign bus.out_valid = out_valid_q;
  assign bus.ps1       = ps1_q;
  assign bus.ps2       = ps2_q;
  assign bus.pd        = pd_q;
  assign bus.old_pd    = old_pd_q;
  assign bus.rd_arch   = rd_arch_q;
  assign bus.ckpt_id   = ckpt_id_q;
endmodule

// File: tb/tb_rename_map_table.sv
// Directed self-checking bench for rename_map_table: renames, x0 handling,
// free-list stalls, checkpoint save/restore/release and counter behaviour.
module tb_rename_map_table;
  localparam int ARCH_REGS  = 32;
  localparam int PHYS_W     = 8;
  localparam int CKPT_DEPTH = 8;
  localparam logic [31:0] NONE = 32'd255;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  int expRenames = 0;
  int expStalls = 0;

  rename_map_table_if #(.ARCH_REGS(ARCH_REGS), .PHYS_W(PHYS_W), .CKPT_DEPTH(CKPT_DEPTH)) bus ();

  rename_map_table #(.ARCH_REGS(ARCH_REGS), .PHYS_W(PHYS_W), .CKPT_DEPTH(CKPT_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic clearInputs();
    bus.rn_valid      = 1'b0;
    bus.rs1_addr      = '0;
    bus.rs2_addr      = '0;
    bus.use_rs1       = 1'b0;
    bus.use_rs2       = 1'b0;
    bus.rd_addr       = '0;
    bus.rd_we         = 1'b0;
    bus.free_phys     = '0;
    bus.free_valid    = 1'b1;
    bus.ckpt_save     = 1'b0;
    bus.restore_valid = 1'b0;
    bus.restore_id    = '0;
    bus.ckpt_release  = 1'b0;
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                               input logic we, input logic [7:0] fp, input logic fv,
                               input logic save);
    bus.rn_valid   = valid;
    bus.rs1_addr   = rs1;
    bus.use_rs1    = u1;
    bus.rs2_addr   = rs2;
    bus.use_rs2    = u2;
    bus.rd_addr    = rd;
    bus.rd_we      = we;
    bus.free_phys  = fp;
    bus.free_valid = fv;
    bus.ckpt_save  = save;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clearInputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
    checkOutput("rst_ps1", 32'(bus.ps1), 0);
    checkOutput("rst_pd", 32'(bus.pd), 0);
    checkOutput("rst_old_pd", 32'(bus.old_pd), 0);
    checkOutput("rst_ckpt_id", 32'(bus.ckpt_id), 0);
    checkOutput("rst_ckpt_full", 32'(bus.ckpt_full), 0);
    reset = 1'b0;
    #1;
    checkOutput("idle_rn_ready", 32'(bus.rn_ready), 1);

    // add x5 <- x3, x4 with free tag 40
    applyStimulus(1, 3, 1, 4, 1, 5, 1, 40, 1, 0);
    checkOutput("t1_rn_ready", 32'(bus.rn_ready), 1);
    checkOutput("t1_free_pop", 32'(bus.free_pop), 1);
    step(); expRenames++;
    checkOutput("t1_out_valid", 32'(bus.out_valid), 1);
    checkOutput("t1_ps1", 32'(bus.ps1), 3);
    checkOutput("t1_ps2", 32'(bus.ps2), 4);
    checkOutput("t1_pd", 32'(bus.pd), 40);
    checkOutput("t1_old_pd", 32'(bus.old_pd), 5);
    checkOutput("t1_rd_arch", 32'(bus.rd_arch), 5);

    applyStimulus(1, 5, 1, 0, 1, 0, 0, 0, 1, 0);
    checkOutput("rd5_free_pop", 32'(bus.free_pop), 0);
    step(); expRenames++;
    checkOutput("rd5_ps1", 32'(bus.ps1), 40);
    checkOutput("rd5_ps2_x0", 32'(bus.ps2), 0);
    checkOutput("rd5_pd", 32'(bus.pd), NONE);
    checkOutput("rd5_old_pd", 32'(bus.old_pd), NONE);

    // write to x0 is never renamed
    applyStimulus(1, 0, 1, 0, 0, 0, 1, 77, 1, 0);
    checkOutput("x0w_rn_ready", 32'(bus.rn_ready), 1);
    checkOutput("x0w_free_pop", 32'(bus.free_pop), 0);
    step(); expRenames++;
    checkOutput("x0w_pd", 32'(bus.pd), NONE);
    checkOutput("x0w_old_pd", 32'(bus.old_pd), NONE);
    checkOutput("x0w_ps2_unused", 32'(bus.ps2), NONE);
    applyStimulus(1, 0, 1, 5, 1, 0, 0, 0, 1, 0);
    step(); expRenames++;
    checkOutput("x0r_ps1", 32'(bus.ps1), 0);
    checkOutput("x0r_ps2", 32'(bus.ps2), 40);

    // empty free list stalls a renaming instruction
    applyStimulus(1, 1, 1, 2, 1, 7, 1, 90, 0, 0);
    checkOutput("fe_rn_ready", 32'(bus.rn_ready), 0);
    checkOutput("fe_free_pop", 32'(bus.free_pop), 0);
    repeat (3) step();
    expStalls += 3;
    checkOutput("fe_out_valid", 32'(bus.out_valid), 0);

    // checkpoint 0, then x5->41, x6->42, then restore with a colliding rename
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("s0_rn_ready", 32'(bus.rn_ready), 1);
    step(); expRenames++;
    checkOutput("s0_ckpt_id", 32'(bus.ckpt_id), 0);
    checkOutput("s0_out_valid", 32'(bus.out_valid), 1);
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 41, 1, 0);
    step(); expRenames++;
    checkOutput("x5_41_old_pd", 32'(bus.old_pd), 40);
    checkOutput("x5_41_pd", 32'(bus.pd), 41);
    applyStimulus(1, 0, 0, 0, 0, 6, 1, 42, 1, 0);
    step(); expRenames++;
    checkOutput("x6_42_old_pd", 32'(bus.old_pd), 6);

    applyStimulus(1, 5, 1, 6, 1, 7, 1, 43, 1, 0);
    bus.restore_valid = 1'b1;
    bus.restore_id    = 3'd0;
    #1;
    checkOutput("rs0_rn_ready", 32'(bus.rn_ready), 0);
    checkOutput("rs0_free_pop", 32'(bus.free_pop), 0);
    step(); expStalls++;
    checkOutput("rs0_out_valid", 32'(bus.out_valid), 0);
    bus.restore_valid = 1'b0;
    applyStimulus(1, 5, 1, 6, 1, 0, 0, 0, 1, 0);
    checkOutput("recover_rn_ready", 32'(bus.rn_ready), 0);
    step(); expStalls++;
    checkOutput("recover_out_valid", 32'(bus.out_valid), 0);
    checkOutput("post_recover_rn_ready", 32'(bus.rn_ready), 1);
    step(); expRenames++;
    checkOutput("rs0_x5", 32'(bus.ps1), 40);
    checkOutput("rs0_x6", 32'(bus.ps2), 6);

    // two releases: the second sees an empty buffer and is ignored
    clearInputs();
    bus.ckpt_release = 1'b1;
    step();
    step();
    bus.ckpt_release = 1'b0;

    // eight saves from tail=1 fill the buffer; slot 3 also renames x9->50
    for (int k = 0; k < 8; k++) begin
      if (k == 2) applyStimulus(1, 0, 0, 0, 0, 9, 1, 50, 1, 1);
      else        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      checkOutput($sformatf("fill%0d_rn_ready", k), 32'(bus.rn_ready), 1);
      step(); expRenames++;
      checkOutput($sformatf("fill%0d_ckpt_id", k), 32'(bus.ckpt_id), 32'((k + 1) % 8));
      if (k == 2) checkOutput("fill_x9_old_pd", 32'(bus.old_pd), 9);
    end
    checkOutput("fill_ckpt_full", 32'(bus.ckpt_full), 1);

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("ninth_rn_ready", 32'(bus.rn_ready), 0);
    step(); expStalls++;
    checkOutput("ninth_out_valid", 32'(bus.out_valid), 0);

    clearInputs();
    bus.ckpt_release = 1'b1;
    step();
    bus.ckpt_release = 1'b0;
    #1;
    checkOutput("rel_ckpt_full", 32'(bus.ckpt_full), 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(); expRenames++;
    checkOutput("wrap_ckpt_id", 32'(bus.ckpt_id), 1);
    checkOutput("wrap_ckpt_full", 32'(bus.ckpt_full), 1);

    // head moves to 5: live slots are 5,6,7,0,1
    clearInputs();
    bus.ckpt_release = 1'b1;
    repeat (3) step();
    bus.ckpt_release = 1'b0;
    #1;
    checkOutput("rel3_ckpt_full", 32'(bus.ckpt_full), 0);
    applyStimulus(1, 0, 0, 0, 0, 9, 1, 60, 1, 0);
    step(); expRenames++;
    checkOutput("x9_60_old_pd", 32'(bus.old_pd), 50);
    checkOutput("x9_60_pd", 32'(bus.pd), 60);

    // restore to slot 3 is outside the live window and must be ignored
    clearInputs();
    bus.restore_valid = 1'b1;
    bus.restore_id    = 3'd3;
    step();
    bus.restore_valid = 1'b0;
    #1;
    checkOutput("badrs_rn_ready", 32'(bus.rn_ready), 1);
    applyStimulus(1, 9, 1, 0, 0, 0, 0, 0, 1, 0);
    step(); expRenames++;
    checkOutput("badrs_x9", 32'(bus.ps1), 60);

    // restore slot 7: tail becomes 0, three slots stay live
    clearInputs();
    bus.restore_valid = 1'b1;
    bus.restore_id    = 3'd7;
    step();
    bus.restore_valid = 1'b0;
    #1;
    checkOutput("rs7_recover_rn_ready", 32'(bus.rn_ready), 0);
    step();
    checkOutput("rs7_run_rn_ready", 32'(bus.rn_ready), 1);
    applyStimulus(1, 9, 1, 5, 1, 0, 0, 0, 1, 0);
    step(); expRenames++;
    checkOutput("rs7_x9", 32'(bus.ps1), 50);
    checkOutput("rs7_x5", 32'(bus.ps2), 40);

    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      step(); expRenames++;
      checkOutput($sformatf("refill%0d_ckpt_id", k), 32'(bus.ckpt_id), 32'(k));
      checkOutput($sformatf("refill%0d_ckpt_full", k), 32'(bus.ckpt_full), (k == 4) ? 32'd1 : 32'd0);
    end
    clearInputs();

`ifdef RMT_PERF_CNT_EN
    checkOutput("perf_rename_cnt", bus.perf_rename_cnt, 32'(expRenames));
    checkOutput("perf_stall_cnt", bus.perf_stall_cnt, 32'(expStalls));
`else
    checkOutput("perf_rename_cnt_off", bus.perf_rename_cnt, 32'd0);
    checkOutput("perf_stall_cnt_off", bus.perf_stall_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
